// File: rtl/rdid_pkg.sv
package rdid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT_CMD,
    SHIFT_RESP,
    CS_HOLD
  } state_t;

  localparam logic [7:0] CMD_RDID = 8'h9F;

endpackage

// File: rtl/rdid_sck_gen.sv
module rdid_sck_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  logic [7:0] div_cnt;
  logic       tick;

  always_comb begin
    tick = en && (div_cnt == 8'(CLK_DIV - 1));
    rise = tick && !sck;
    fall = tick && sck;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck     <= 1'b0;
      div_cnt <= '0;
    end else if (!en) begin
      sck     <= 1'b0;
      div_cnt <= '0;
    end else if (tick) begin
      sck     <= ~sck;
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/rdid_controller.sv
module rdid_controller
  import rdid_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter logic [7:0]  CMD        = CMD_RDID,
  parameter int unsigned RESP_BYTES = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn_debounced,
  input  logic                    spi_miso,
  output logic                    spi_sck,
  output logic                    spi_cs_n,
  output logic                    spi_mosi,
  output logic [8*RESP_BYTES-1:0] id_data,
  output logic                    id_valid,
  output logic                    busy
);

  localparam int unsigned RESP_BITS = 8 * RESP_BYTES;
  localparam int unsigned CNT_W     = $clog2(RESP_BITS);

  state_t               state;
  logic                 btn_q;
  logic                 trig;
  logic                 sck_en;
  logic                 sck_rise;
  logic                 sck_fall;
  logic [7:0]           wait_cnt;
  logic [CNT_W-1:0]     bit_cnt;
  logic [6:0]           cmd_sr;
  logic [RESP_BITS-1:0] resp_sr;

  always_comb begin
    trig   = btn_debounced && !btn_q;
    sck_en = (state == SHIFT_CMD) || (state == SHIFT_RESP);
  end

  rdid_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk  (clk),
    .reset(reset),
    .en   (sck_en),
    .sck  (spi_sck),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  // CS_SETUP is a full CLK_DIV wait ahead of the first SCK low phase; the
  // divider only runs in the shift states, so the command and response
  // phases share one continuous SCK train.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      btn_q    <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_mosi <= 1'b0;
      id_data  <= '0;
      id_valid <= 1'b0;
      busy     <= 1'b0;
      wait_cnt <= '0;
      bit_cnt  <= '0;
      cmd_sr   <= '0;
      resp_sr  <= '0;
    end else begin
      btn_q <= btn_debounced;
      case (state)
        IDLE: begin
          if (trig) begin
            state    <= CS_SETUP;
            spi_cs_n <= 1'b0;
            busy     <= 1'b1;
            id_valid <= 1'b0;
            spi_mosi <= CMD[7];
            cmd_sr   <= CMD[6:0];
            wait_cnt <= '0;
            bit_cnt  <= '0;
            resp_sr  <= '0;
          end
        end
        CS_SETUP: begin
          if (wait_cnt == 8'(CLK_DIV - 1)) begin
            wait_cnt <= '0;
            state    <= SHIFT_CMD;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        SHIFT_CMD: begin
          if (sck_fall) begin
            if (bit_cnt == CNT_W'(7)) begin
              bit_cnt  <= '0;
              spi_mosi <= 1'b0;
              state    <= SHIFT_RESP;
            end else begin
              bit_cnt  <= bit_cnt + CNT_W'(1);
              spi_mosi <= cmd_sr[6];
              cmd_sr   <= {cmd_sr[5:0], 1'b0};
            end
          end
        end
        SHIFT_RESP: begin
          if (sck_rise) begin
            resp_sr <= {resp_sr[RESP_BITS-2:0], spi_miso};
          end
          if (sck_fall) begin
            if (bit_cnt == CNT_W'(RESP_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= CS_HOLD;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        CS_HOLD: begin
          if (wait_cnt == 8'(CLK_DIV - 1)) begin
            wait_cnt <= '0;
            state    <= IDLE;
            spi_cs_n <= 1'b1;
            busy     <= 1'b0;
            id_data  <= resp_sr;
            id_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rdid_controller.sv
module tb_rdid_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        btn;
  logic        miso = 1'b0;
  logic        sck, cs_n, mosi, id_valid, busy;
  logic [23:0] id_data;

  logic        btn2;
  logic        miso2 = 1'b0;
  logic        sck2, cs2_n, mosi2, id_valid2, busy2;
  logic [23:0] id_data2;

  rdid_controller #(
    .CLK_DIV   (4),
    .CMD       (8'h9F),
    .RESP_BYTES(3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_debounced(btn),
    .spi_miso     (miso),
    .spi_sck      (sck),
    .spi_cs_n     (cs_n),
    .spi_mosi     (mosi),
    .id_data      (id_data),
    .id_valid     (id_valid),
    .busy         (busy)
  );

  rdid_controller #(
    .CLK_DIV   (2),
    .CMD       (8'h9F),
    .RESP_BYTES(3)
  ) dut2 (
    .clk          (clk),
    .reset        (reset),
    .btn_debounced(btn2),
    .spi_miso     (miso2),
    .spi_sck      (sck2),
    .spi_cs_n     (cs2_n),
    .spi_mosi     (mosi2),
    .id_data      (id_data2),
    .id_valid     (id_valid2),
    .busy         (busy2)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Flash model for dut: captures the command on SCK rise, drives response on SCK fall
  logic [23:0] flash_resp = '0;
  logic [7:0]  cmd_byte = '0;
  int          rise_n = 0;
  int          txn_starts = 0;

  always @(negedge cs_n) begin
    rise_n = 0;
    cmd_byte = '0;
    txn_starts++;
  end

  always @(posedge sck) begin
    if (!cs_n) begin
      if (rise_n < 8) cmd_byte = {cmd_byte[6:0], mosi};
      rise_n++;
    end
  end

  always @(negedge sck) begin
    if (!cs_n && rise_n >= 8 && rise_n < 32) miso = flash_resp[31 - rise_n];
  end

  // Flash model for dut2: corrupts MISO right after every SCK rise
  logic [23:0] flash_resp2 = '0;
  logic [7:0]  cmd2 = '0;
  int          rise2 = 0;

  always @(negedge cs2_n) begin
    rise2 = 0;
    cmd2 = '0;
  end

  always @(posedge sck2) begin
    if (!cs2_n) begin
      if (rise2 < 8) cmd2 = {cmd2[6:0], mosi2};
      rise2++;
      #1 miso2 = ~miso2;
    end
  end

  always @(negedge sck2) begin
    if (!cs2_n && rise2 >= 8 && rise2 < 32) miso2 = flash_resp2[31 - rise2];
  end

  // Scoreboard
  typedef struct {
    logic [23:0] id;
    int          width;
  } exp_t;

  exp_t sb_q[$];

  task automatic push(input logic [23:0] id, input int width);
    exp_t e;
    e.id = id;
    e.width = width;
    sb_q.push_back(e);
  endtask

  logic        busy_q = 1'b0;
  int          busy_len = 0;
  logic        partial = 1'b0;
  logic [23:0] last_id = '0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy_q   = 1'b0;
      busy_len = 0;
      partial  = 1'b0;
      last_id  = '0;
    end else begin
      if (busy && !busy_q) begin
        check("trig_id_valid_low", 32'(id_valid), 32'd0);
        check("trig_id_hold", 32'(id_data), 32'(last_id));
      end
      if (busy) begin
        busy_len++;
        if (id_data !== last_id) partial = 1'b1;
      end
      if (!busy && busy_q) begin
        if (sb_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_txn: got completion expected none (id %0h)", id_data);
        end else begin
          e = sb_q.pop_front();
          check("id_data", 32'(id_data), 32'(e.id));
          check("id_valid", 32'(id_valid), 32'd1);
          check("cs_n_high", 32'(cs_n), 32'd1);
          check("busy_width", 32'(busy_len), 32'(e.width));
          check("cmd_byte", 32'(cmd_byte), 32'h9F);
          check("no_partial", 32'(partial), 32'd0);
          last_id = e.id;
        end
        busy_len = 0;
        partial  = 1'b0;
      end
      busy_q = busy;
    end
  end

  task automatic press(input int hold);
    @(negedge clk);
    btn = 1'b1;
    repeat (hold) @(negedge clk);
    btn = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int n;
    int len;

    reset = 1'b1;
    btn   = 1'b0;
    btn2  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_id_data", 32'(id_data), 32'd0);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    flash_resp = 24'h20BA19;
    push(24'h20BA19, 264);
    press(10);
    wait_done();

    flash_resp = 24'hEF4018;
    push(24'hEF4018, 264);
    press(10);
    wait_done();

    flash_resp = 24'hC22017;
    push(24'hC22017, 264);
    s = txn_starts;
    @(negedge clk) btn = 1'b1;
    repeat (20) @(negedge clk);
    btn = 1'b0;
    repeat (10) @(negedge clk);
    btn = 1'b1;
    repeat (40) @(negedge clk);
    btn = 1'b0;
    repeat (40) @(negedge clk);
    btn = 1'b1;
    repeat (40) @(negedge clk);
    btn = 1'b0;
    wait_done();
    repeat (20) @(negedge clk);
    check("single_txn", 32'(txn_starts - s), 32'd1);
    check("still_idle", 32'(busy), 32'd0);

    flash_resp = 24'h777777;
    @(negedge clk) btn = 1'b1;
    repeat (100) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_cs_n", 32'(cs_n), 32'd1);
    check("abort_sck", 32'(sck), 32'd0);
    check("abort_mosi", 32'(mosi), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_id_valid", 32'(id_valid), 32'd0);
    check("abort_id_data", 32'(id_data), 32'd0);
    btn = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    flash_resp = 24'h1A2B3C;
    push(24'h1A2B3C, 264);
    press(10);
    wait_done();

    flash_resp = 24'h5A3C81;
    push(24'h5A3C81, 264);
    push(24'h5A3C81, 264);
    press(5);
    wait_done();
    btn = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_cs_n", 32'(cs_n), 32'd0);
    @(negedge clk) btn = 1'b0;
    wait_done();

    flash_resp2 = 24'hA5C3F0;
    @(negedge clk) btn2 = 1'b1;
    n = 0;
    while (!busy2 && n < 10) begin
      @(negedge clk);
      n++;
    end
    btn2 = 1'b0;
    len = 0;
    while (busy2 && len < 1000) begin
      @(negedge clk);
      len++;
    end
    check("div2_busy_width", 32'(len), 32'd132);
    check("div2_id_data", 32'(id_data2), 32'hA5C3F0);
    check("div2_id_valid", 32'(id_valid2), 32'd1);
    check("div2_cmd_byte", 32'(cmd2), 32'h9F);

    reset = 1'b1;
    btn   = 1'b1;
    repeat (2) @(negedge clk);
    flash_resp = 24'h0C0FFE;
    push(24'h0C0FFE, 264);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rel_trig_busy", 32'(busy), 32'd1);
    check("rel_trig_cs_n", 32'(cs_n), 32'd0);
    @(negedge clk) btn = 1'b0;
    wait_done();

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
